// File: rtl/adder_window_accum_if.sv
// Sample/result bundle for adder_window_accum: sample strobe and controls in,
// registered sum and window status out.
interface adder_window_accum_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int ACC_W = 16
) ();
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             mode;
  logic             clear;
  logic             sum_valid;
  logic [ACC_W-1:0] sum;
  logic             sat;
  logic [CNT_W-1:0] fill_count;
  logic             window_full;

  modport master (
    output in_valid, in_data, mode, clear,
    input  sum_valid, sum, sat, fill_count, window_full
  );

  modport slave (
    input  in_valid, in_data, mode, clear,
    output sum_valid, sum, sat, fill_count, window_full
  );
endinterface

// File: rtl/adder_window_accum.sv
// Streaming sample accumulator: running sum (saturating or wrapping, sticky
// overflow flag) or moving-window sum over the last DEPTH samples.
module adder_window_accum #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int ACC_W    = 16,
  parameter bit SATURATE = 1'b1
) (
  input logic                 clk,
  input logic                 rst_n,
  adder_window_accum_if.slave bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic {
    MODE_RUN = 1'b0,
    MODE_WIN = 1'b1
  } mode_e;

  mode_e            mode_in;
  mode_e            mode_q;
  logic [ACC_W-1:0] sum_q, sum_n;
  logic             sat_q, sat_n;
  logic             valid_q, valid_n;
  logic [CNT_W-1:0] fill_q, fill_n;
  logic [PTR_W-1:0] ptr_q, ptr_n;
  logic [WIDTH-1:0] win_buf [DEPTH];

  logic             switch_mode;
  logic             do_clear;
  logic             accept;
  logic             buf_clr;
  logic             buf_wr;
  logic [ACC_W-1:0] base_sum;
  logic             base_sat;
  logic [CNT_W-1:0] base_fill;
  logic [PTR_W-1:0] base_ptr;
  logic             base_full;
  logic [ACC_W-1:0] sample_ext;
  logic [ACC_W-1:0] oldest_ext;
  logic [ACC_W:0]   run_next;

  assign mode_in     = mode_e'(bus.mode);
  assign switch_mode = (mode_in != mode_q);
  assign do_clear    = bus.clear | switch_mode;
  // A sample arriving on a mode-switch edge is dropped; an explicit clear keeps it.
  assign accept      = bus.in_valid & ~switch_mode;

  // The clear is applied first, so an accepted sample sees a zeroed state.
  assign base_sum  = do_clear ? '0 : sum_q;
  assign base_sat  = do_clear ? 1'b0 : sat_q;
  assign base_fill = do_clear ? '0 : fill_q;
  assign base_ptr  = do_clear ? '0 : ptr_q;
  assign base_full = (base_fill == FULL_CNT);

  assign sample_ext = ACC_W'(bus.in_data);
  assign oldest_ext = base_full ? ACC_W'(win_buf[base_ptr]) : '0;
  assign run_next   = {1'b0, base_sum} + {1'b0, sample_ext};

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    sum_n   = base_sum;
    sat_n   = base_sat;
    fill_n  = base_fill;
    ptr_n   = base_ptr;
    valid_n = 1'b0;
    buf_clr = do_clear;
    buf_wr  = accept;

    if (accept) begin
      valid_n = 1'b1;
      ptr_n   = base_ptr + PTR_W'(1);
      if (!base_full) begin
        fill_n = base_fill + CNT_W'(1);
      end

      if (mode_in == MODE_RUN) begin
        if (run_next[ACC_W]) begin
          sat_n = 1'b1;
          sum_n = SATURATE ? '1 : run_next[ACC_W-1:0];
        end else begin
          sum_n = run_next[ACC_W-1:0];
        end
      end else begin
        // ACC_W >= WIDTH + log2(DEPTH) guarantees this never over- or underflows.
        sum_n = base_sum + sample_ext - oldest_ext;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= MODE_RUN;
      sum_q   <= '0;
      sat_q   <= 1'b0;
      valid_q <= 1'b0;
      fill_q  <= '0;
      ptr_q   <= '0;
    end else begin
      mode_q  <= mode_in;
      sum_q   <= sum_n;
      sat_q   <= sat_n;
      valid_q <= valid_n;
      fill_q  <= fill_n;
      ptr_q   <= ptr_n;
    end
  end

  // NOTE: the window buffer is small and must read as zero after reset or
  // clear, so it is built from resettable flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        win_buf[i] <= '0;
      end
    end else begin
      if (buf_clr) begin
        for (int i = 0; i < DEPTH; i++) begin
          win_buf[i] <= '0;
        end
      end
      // Later assignment wins, so clear-plus-sample leaves the new sample in slot 0.
      if (buf_wr) begin
        win_buf[base_ptr] <= bus.in_data;
      end
    end
  end

  assign bus.sum         = sum_q;
  assign bus.sum_valid   = valid_q;
  assign bus.sat         = sat_q;
  assign bus.fill_count  = fill_q;
  assign bus.window_full = (fill_q == FULL_CNT);
endmodule

// File: tb/tb_adder_window_accum.sv
// Scoreboard bench for adder_window_accum: three configurations (16-bit
// saturating, 10-bit saturating, 10-bit wrapping) share one stimulus stream.
module tb_adder_window_accum;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int NCFG  = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  adder_window_accum_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ACC_W(16)) if_a ();
  adder_window_accum_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ACC_W(10)) if_s ();
  adder_window_accum_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ACC_W(10)) if_w ();

  adder_window_accum #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ACC_W(16), .SATURATE(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a.slave));
  adder_window_accum #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ACC_W(10), .SATURATE(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n), .bus(if_s.slave));
  adder_window_accum #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ACC_W(10), .SATURATE(1'b0)) dut_w (
    .clk(clk), .rst_n(rst_n), .bus(if_w.slave));

  typedef struct {
    logic [31:0] valid;
    logic [31:0] sum;
    logic [31:0] sat;
    logic [31:0] fill;
    logic [31:0] full;
  } exp_t;

  exp_t sb_q[$];
  int compared   = 0;
  int mismatched = 0;

  int unsigned sum_max [NCFG] = '{65535, 1023, 1023};
  bit          sat_cfg [NCFG] = '{1'b1, 1'b1, 1'b0};
  int unsigned m_sum   [NCFG];
  bit          m_sat   [NCFG];
  bit          m_mode;
  int unsigned m_win[$];

  function automatic void model_reset();
    for (int k = 0; k < NCFG; k++) begin
      m_sum[k] = 0;
      m_sat[k] = 1'b0;
    end
    m_mode = 1'b0;
    m_win.delete();
  endfunction

  function automatic void push_exp(bit valid);
    exp_t e;
    for (int k = 0; k < NCFG; k++) begin
      e.valid = 32'(valid);
      e.sum   = 32'(m_sum[k]);
      e.sat   = 32'(m_sat[k]);
      e.fill  = 32'(m_win.size());
      e.full  = 32'(m_win.size() == DEPTH);
      sb_q.push_back(e);
    end
  endfunction

  // Window model keeps the literal list of recent samples and re-sums it.
  function automatic void model_step(bit v, int unsigned d, bit m, bit c);
    bit          sw;
    bit          acc;
    int unsigned nxt;
    int unsigned wsum;
    sw     = (m != m_mode);
    acc    = v && !sw;
    m_mode = m;
    if (c || sw) begin
      m_win.delete();
      for (int k = 0; k < NCFG; k++) begin
        m_sum[k] = 0;
        m_sat[k] = 1'b0;
      end
    end
    if (acc) begin
      m_win.push_back(d);
      if (m_win.size() > DEPTH) void'(m_win.pop_front());
      wsum = 0;
      foreach (m_win[i]) wsum += m_win[i];
      for (int k = 0; k < NCFG; k++) begin
        if (!m) begin
          nxt = m_sum[k] + d;
          if (nxt > sum_max[k]) begin
            m_sat[k] = 1'b1;
            m_sum[k] = sat_cfg[k] ? sum_max[k] : nxt - (sum_max[k] + 1);
          end else begin
            m_sum[k] = nxt;
          end
        end else begin
          m_sum[k] = wsum;
        end
      end
    end
    push_exp(acc);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic compare_pop(input string tag);
    exp_t        e;
    logic [31:0] g_valid [NCFG];
    logic [31:0] g_sum   [NCFG];
    logic [31:0] g_sat   [NCFG];
    logic [31:0] g_fill  [NCFG];
    logic [31:0] g_full  [NCFG];
    g_valid[0] = 32'(if_a.sum_valid);  g_sum[0] = 32'(if_a.sum);  g_sat[0] = 32'(if_a.sat);
    g_valid[1] = 32'(if_s.sum_valid);  g_sum[1] = 32'(if_s.sum);  g_sat[1] = 32'(if_s.sat);
    g_valid[2] = 32'(if_w.sum_valid);  g_sum[2] = 32'(if_w.sum);  g_sat[2] = 32'(if_w.sat);
    g_fill[0] = 32'(if_a.fill_count);  g_full[0] = 32'(if_a.window_full);
    g_fill[1] = 32'(if_s.fill_count);  g_full[1] = 32'(if_s.window_full);
    g_fill[2] = 32'(if_w.fill_count);  g_full[2] = 32'(if_w.window_full);
    for (int k = 0; k < NCFG; k++) begin
      if (sb_q.size() == 0) begin
        check($sformatf("%s.scoreboard_empty[%0d]", tag, k), 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check($sformatf("%s.sum_valid[%0d]", tag, k), g_valid[k], e.valid);
        check($sformatf("%s.sum[%0d]", tag, k), g_sum[k], e.sum);
        check($sformatf("%s.sat[%0d]", tag, k), g_sat[k], e.sat);
        check($sformatf("%s.fill_count[%0d]", tag, k), g_fill[k], e.fill);
        check($sformatf("%s.window_full[%0d]", tag, k), g_full[k], e.full);
      end
    end
  endtask

  task automatic drive(input bit v, input int unsigned d, input bit m, input bit c);
    logic [31:0] dv;
    dv = d;
    if_a.in_valid = v;  if_a.in_data = dv[WIDTH-1:0];  if_a.mode = m;  if_a.clear = c;
    if_s.in_valid = v;  if_s.in_data = dv[WIDTH-1:0];  if_s.mode = m;  if_s.clear = c;
    if_w.in_valid = v;  if_w.in_data = dv[WIDTH-1:0];  if_w.mode = m;  if_w.clear = c;
  endtask

  // Drive one cycle, predict it, then compare just after the edge.
  task automatic step(input bit v, input int unsigned d, input bit m, input bit c,
                      input string tag);
    drive(v, d, m, c);
    model_step(v, d, m, c);
    @(posedge clk);
    #1;
    compare_pop(tag);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 0, 1'b0, 1'b0);
    model_reset();
    #2;
    push_exp(1'b0);
    compare_pop("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Running accumulation
    step(1'b1, 10, 1'b0, 1'b0, "run10");
    step(1'b1, 20, 1'b0, 1'b0, "run20");
    step(1'b1, 30, 1'b0, 1'b0, "run30");
    step(1'b0, 0,  1'b0, 1'b0, "run_idle");
    step(1'b0, 0,  1'b0, 1'b1, "clear_only");

    // Overflow: saturate vs wrap, sticky flag
    for (int i = 0; i < 6; i++) step(1'b1, 255, 1'b0, 1'b0, $sformatf("ovf%0d", i));
    step(1'b0, 0,   1'b0, 1'b1, "ovf_clear");
    step(1'b1, 255, 1'b0, 1'b0, "post_clear0");
    step(1'b1, 255, 1'b0, 1'b0, "post_clear1");

    // Mode switch drops the sample and clears
    step(1'b1, 9, 1'b1, 1'b0, "switch_drop");

    // Moving window, including fill and first eviction
    for (int i = 1; i <= 6; i++) step(1'b1, i, 1'b1, 1'b0, $sformatf("win%0d", i));

    // Clear with a sample, then wrap the pointer and evict the cleared-in sample
    step(1'b1, 7, 1'b1, 1'b1, "clear_with_sample");
    for (int i = 2; i <= 5; i++) step(1'b1, i, 1'b1, 1'b0, $sformatf("wrap%0d", i));

    // Asynchronous reset mid-window
    step(1'b1, 1, 1'b1, 1'b1, "pre_rst1");
    step(1'b1, 2, 1'b1, 1'b0, "pre_rst2");
    step(1'b1, 3, 1'b1, 1'b0, "pre_rst3");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    push_exp(1'b0);
    compare_pop("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 8, 1'b0, 1'b0, "post_rst8");
    step(1'b0, 0, 1'b0, 1'b0, "final_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
